// File: rtl/pipe_pattern_checker_if.sv
// FIFO read-side bundle between the okClk->sys_clk FIFO (master) and the pattern checker (slave).
`timescale 1ns/1ps
interface pipe_pattern_checker_if #(
  parameter int unsigned DATA_W = 128
);
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_valid;

  modport master (
    output fifo_empty,
    output fifo_dout,
    output fifo_valid,
    input  fifo_rd_en
  );

  modport slave (
    input  fifo_empty,
    input  fifo_dout,
    input  fifo_valid,
    output fifo_rd_en
  );
endinterface

// File: rtl/pipe_pattern_checker.sv
// Host->FPGA pipe speed-test sink: drains the FIFO and checks words against an incrementing pattern.
// Define PIPE_CHK_CAPTURE_EN to add first-mismatch data/expected capture outputs.
`timescale 1ns/1ps
module pipe_pattern_checker #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      target_words,
  pipe_pattern_checker_if.slave fifo,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  err_flag,
  output logic [CNT_W-1:0]      word_count,
  output logic [CNT_W-1:0]      error_count,
  output logic [CNT_W-1:0]      first_err_idx
`ifdef PIPE_CHK_CAPTURE_EN
  ,
  output logic [DATA_W-1:0]     first_err_data,
  output logic [DATA_W-1:0]     first_err_expect
`endif
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [DATA_W-1:0]  expected_q, expected_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic [CNT_W-1:0]   error_count_q, error_count_d;
  logic [CNT_W-1:0]   first_err_idx_q, first_err_idx_d;
  logic               err_flag_q, err_flag_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [DATA_W-1:0]  cap_data_q, cap_data_d;
  logic [DATA_W-1:0]  cap_exp_q, cap_exp_d;
  logic               rd_en_c;
  logic               mismatch_c;

  // Read issue is throttled by the issued count so a bounded run never over-reads the FIFO.
  always_comb begin
    rd_en_c    = (state_q == ST_RUN) && !fifo.fifo_empty &&
                 ((target_q == '0) || (issued_q < target_q));
    mismatch_c = (fifo.fifo_dout != expected_q);
  end

  assign fifo.fifo_rd_en = rd_en_c;

  // Next-state and datapath: start has top priority, abort only acts in RUN.
  always_comb begin
    state_d         = state_q;
    target_d        = target_q;
    issued_d        = issued_q;
    expected_d      = expected_q;
    word_count_d    = word_count_q;
    error_count_d   = error_count_q;
    first_err_idx_d = first_err_idx_q;
    err_flag_d      = err_flag_q;
    cap_data_d      = cap_data_q;
    cap_exp_d       = cap_exp_q;

    if (start) begin
      state_d         = ST_RUN;
      target_d        = target_words;
      issued_d        = '0;
      expected_d      = '0;
      word_count_d    = '0;
      error_count_d   = '0;
      first_err_idx_d = CNT_MAX;
      err_flag_d      = 1'b0;
      cap_data_d      = '0;
      cap_exp_d       = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (abort) begin
            state_d = ST_IDLE;
          end else begin
            if (rd_en_c) begin
              issued_d = issued_q + CNT_ONE;
            end
            if (fifo.fifo_valid) begin
              expected_d   = expected_q + DATA_ONE;
              word_count_d = word_count_q + CNT_ONE;
              if (mismatch_c) begin
                err_flag_d = 1'b1;
                if (error_count_q != CNT_MAX) begin
                  error_count_d = error_count_q + CNT_ONE;
                end
                if (!err_flag_q) begin
                  first_err_idx_d = word_count_q;
                  cap_data_d      = fifo.fifo_dout;
                  cap_exp_d       = expected_q;
                end
              end
              if ((target_q != '0) && (word_count_d == target_q)) begin
                state_d = ST_DONE;
              end
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (error_count_d == '0);
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      target_q        <= '0;
      issued_q        <= '0;
      expected_q      <= '0;
      word_count_q    <= '0;
      error_count_q   <= '0;
      first_err_idx_q <= CNT_MAX;
      err_flag_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      cap_data_q      <= '0;
      cap_exp_q       <= '0;
    end else begin
      state_q         <= state_d;
      target_q        <= target_d;
      issued_q        <= issued_d;
      expected_q      <= expected_d;
      word_count_q    <= word_count_d;
      error_count_q   <= error_count_d;
      first_err_idx_q <= first_err_idx_d;
      err_flag_q      <= err_flag_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      cap_data_q      <= cap_data_d;
      cap_exp_q       <= cap_exp_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_flag      = err_flag_q;
  assign word_count    = word_count_q;
  assign error_count   = error_count_q;
  assign first_err_idx = first_err_idx_q;

`ifdef PIPE_CHK_CAPTURE_EN
  assign first_err_data   = cap_data_q;
  assign first_err_expect = cap_exp_q;
`else
  logic unused_cap_c;
  assign unused_cap_c = ^{cap_data_q, cap_exp_q};
`endif

endmodule

// File: tb/tb_pipe_pattern_checker.sv
// Self-checking bench for pipe_pattern_checker: FIFO emulator, behavioural model and per-cycle compare.
`timescale 1ns/1ps
module tb_pipe_pattern_checker;
  localparam int unsigned DW = 128;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] target_words = '0;
  logic          busy, done, pass, err_flag;
  logic [CW-1:0] word_count, error_count, first_err_idx;
`ifdef PIPE_CHK_CAPTURE_EN
  logic [DW-1:0] first_err_data, first_err_expect;
`endif

  pipe_pattern_checker_if #(.DATA_W(DW)) fif ();

  pipe_pattern_checker #(.DATA_W(DW), .CNT_W(CW)) dut (
    .sys_clk       (clk),
    .rstn          (rstn),
    .start         (start),
    .abort         (abort),
    .target_words  (target_words),
    .fifo          (fif.slave),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_flag      (err_flag),
    .word_count    (word_count),
    .error_count   (error_count),
    .first_err_idx (first_err_idx)
`ifdef PIPE_CHK_CAPTURE_EN
    ,
    .first_err_data   (first_err_data),
    .first_err_expect (first_err_expect)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int nprint = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (nprint < 40) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      nprint++;
    end
  endtask

  // FIFO emulator: data appears one cycle after an accepted read
  logic [DW-1:0] q[$];
  int  rd_cnt = 0;
  int  rd_while_empty = 0;
  int  vcnt = 0;
  int  cyc = 0;
  bit  gate_en = 0;

  initial begin
    bit rd;
    fif.fifo_empty = 1'b1;
    fif.fifo_valid = 1'b0;
    fif.fifo_dout  = '0;
    forever begin
      @(negedge clk);
      rd = (fif.fifo_rd_en === 1'b1);
      if (rd) rd_cnt++;
      if (rd && fif.fifo_empty) rd_while_empty++;
      @(posedge clk);
      #1;
      if (rd && q.size() > 0) begin
        fif.fifo_dout  = q.pop_front();
        fif.fifo_valid = 1'b1;
      end else begin
        fif.fifo_valid = 1'b0;
      end
      cyc++;
      fif.fifo_empty = (q.size() == 0) || (gate_en && cyc[1]);
    end
  end

  // Behavioural model: the expected word is simply how many words were seen since start
  bit            m_busy, m_done, m_err;
  longint        m_seen;
  logic [CW-1:0] m_wc, m_ec, m_fi, m_tgt, m_iss;
  logic [DW-1:0] m_fd, m_fe;

  task automatic m_clear();
    m_err = 0; m_seen = 0; m_wc = '0; m_ec = '0; m_fi = '1; m_iss = '0;
    m_fd = '0; m_fe = '0;
  endtask

  task automatic m_reset();
    m_busy = 0; m_done = 0; m_tgt = '0;
    m_clear();
  endtask

  function automatic bit m_rd();
    return m_busy && !fif.fifo_empty && (m_tgt == 0 || m_iss < m_tgt);
  endfunction

  task automatic m_step();
    bit rd;
    rd = m_rd();
    if (start) begin
      m_clear();
      m_busy = 1; m_done = 0; m_tgt = target_words;
    end else if (m_busy && abort) begin
      m_busy = 0;
    end else if (m_busy) begin
      if (rd) m_iss++;
      if (fif.fifo_valid) begin
        if (fif.fifo_dout !== DW'(m_seen)) begin
          if (m_ec != '1) m_ec++;
          if (!m_err) begin
            m_fi = m_wc; m_fd = fif.fifo_dout; m_fe = DW'(m_seen);
          end
          m_err = 1;
        end
        m_seen++;
        m_wc++;
        if (m_tgt != 0 && m_wc == m_tgt) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) m_reset();
      else m_step();
    end
  end

  // Per-cycle compare of every DUT output against the model
  bit chk_en = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (fif.fifo_valid) vcnt++;
      if (chk_en) begin
        chk("rd_en", fif.fifo_rd_en, m_rd());
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("pass", pass, m_done && m_ec == 0);
        chk("err_flag", err_flag, m_err);
        chk("word_count", word_count, m_wc);
        chk("error_count", error_count, m_ec);
        chk("first_err_idx", first_err_idx, m_fi);
`ifdef PIPE_CHK_CAPTURE_EN
        chk("first_err_data", first_err_data, m_fd);
        chk("first_err_expect", first_err_expect, m_fe);
`endif
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_pattern(input int n);
    for (int i = 0; i < n; i++) q.push_back(DW'(i));
  endtask

  task automatic pulse_start(input int t);
    target_words = CW'(t);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400 && done !== 1'b1; i++) tick();
    chk(name, done, 1'b1);
  endtask

  task automatic flush();
    q.delete();
    tick(3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t;
    rstn = 1'b0;
    tick(3);
    rstn = 1'b1;
    chk_en = 1;
    tick(2);
    chk("rst_busy", busy, 1'b0);
    chk("rst_first_idx", first_err_idx, 32'hFFFF_FFFF);
    chk("rst_word_count", word_count, 0);

    // back-to-back, target 4
    rd_cnt = 0;
    push_pattern(4);
    pulse_start(4);
    wait_done("t1_done");
    chk("t1_pass", pass, 1'b1);
    chk("t1_wc", word_count, 4);
    chk("t1_ec", error_count, 0);
    chk("t1_fi", first_err_idx, 32'hFFFF_FFFF);
    chk("t1_rd_pulses", DW'(rd_cnt), 4);

    // one corrupt word at index 5
    for (int i = 0; i < 8; i++) q.push_back(i == 5 ? DW'(16'hDEAD) : DW'(i));
    pulse_start(8);
    wait_done("t2_done");
    chk("t2_ec", error_count, 1);
    chk("t2_fi", first_err_idx, 5);
    chk("t2_err_flag", err_flag, 1'b1);
    chk("t2_pass", pass, 1'b0);
`ifdef PIPE_CHK_CAPTURE_EN
    chk("t2_cap_data", first_err_data, 16'hDEAD);
    chk("t2_cap_exp", first_err_expect, 5);
`endif

    // over-full FIFO, target 3
    rd_cnt = 0;
    push_pattern(10);
    pulse_start(3);
    wait_done("t3_done");
    tick(3);
    chk("t3_rd_pulses", DW'(rd_cnt), 3);
    chk("t3_left", DW'(q.size()), 7);
    flush();

    // empty toggling every 2 cycles, target 6
    gate_en = 1;
    rd_while_empty = 0;
    push_pattern(6);
    pulse_start(6);
    wait_done("t4_done");
    chk("t4_wc", word_count, 6);
    chk("t4_pass", pass, 1'b1);
    chk("t4_rd_while_empty", DW'(rd_while_empty), 0);
    gate_en = 0;
    tick(2);

    // unbounded run aborted after 12 valids
    push_pattern(20);
    pulse_start(0);
    vcnt = 0;
    for (int i = 0; i < 200 && vcnt < 12; i++) tick();
    chk("t5_saw12", DW'(vcnt >= 12), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(4);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_wc", word_count, 12);
    flush();
    push_pattern(5);
    pulse_start(5);
    wait_done("t5_restart_done");
    chk("t5_restart_wc", word_count, 5);
    chk("t5_restart_pass", pass, 1'b1);

    // restart while running: remaining old words become mismatches
    push_pattern(8);
    pulse_start(8);
    tick(6);
    pulse_start(8);
    tick(10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    flush();

    // randomized runs
    for (int it = 0; it < 12; it++) begin
      gate_en = bit'($urandom_range(0, 1));
      n = int'($urandom_range(1, 16));
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(0, 5) == 0) ? DW'($urandom) : DW'(i));
      t = int'($urandom_range(1, n));
      pulse_start(t);
      wait_done("rand_done");
      tick(2);
      gate_en = 0;
      flush();
    end

    // async reset mid-run with two errors recorded
    for (int i = 0; i < 10; i++) q.push_back((i == 1 || i == 2) ? DW'(32'hBAD0 + i) : DW'(i));
    pulse_start(10);
    for (int i = 0; i < 200 && error_count != 2; i++) tick();
    chk("t8_ec2", error_count, 2);
    #1;
    rstn = 1'b0;
    #1;
    chk("t8_busy", busy, 1'b0);
    chk("t8_done", done, 1'b0);
    chk("t8_pass", pass, 1'b0);
    chk("t8_err_flag", err_flag, 1'b0);
    chk("t8_wc", word_count, 0);
    chk("t8_ec", error_count, 0);
    chk("t8_fi", first_err_idx, 32'hFFFF_FFFF);
    chk("t8_rd_en", fif.fifo_rd_en, 1'b0);
    q.delete();
    tick(2);
    rstn = 1'b1;
    tick(3);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
